button_bank: RTL
================

Name: button_bank

Overview:
- Multi-channel debounced button/switch front end; successor to the single-pin edge detector.
- Handles N independent pins, each with per-channel active polarity.
- Per channel: synchronizes the pin, debounces both edges, and produces one-cycle press/release pulses, a debounced level and a one-shot long-press pulse.
- Sits between board-level pushbuttons/switches and control logic in the CLK domain.

Parameters:
- CHANNELS, 4, number of independent pins.
- ACTIVE_MASK, {CHANNELS{1'b1}}, bit i = 1: channel i is active-high; bit i = 0: active-low.
- CLOCKS_PER_USEC, 125, CLK cycles per microsecond.
- DEBOUNCE_USEC, 10000, debounce time; DEBOUNCE_PERIOD = CLOCKS_PER_USEC*DEBOUNCE_USEC cycles, must be >= 2.
- LONG_PRESS_USEC, 1000000, long-press time; LONG_PERIOD = CLOCKS_PER_USEC*LONG_PRESS_USEC cycles, must be > DEBOUNCE_PERIOD.

Ports:
- CLK  input  1  system clock; all logic on posedge.
- RESET  input  1  synchronous, active-high reset.
- PIN  input  CHANNELS  raw asynchronous pins.
- STATE  output  CHANNELS  debounced logical level; 1 = active, independent of polarity.
- PRESS  output  CHANNELS  one-cycle pulse on debounced inactive->active transition.
- RELEASE  output  CHANNELS  one-cycle pulse on debounced active->inactive transition.
- LONG  output  CHANNELS  one-cycle pulse when a press has been held LONG_PERIOD cycles.

Behaviour:
- Channels are fully independent; everything below applies per channel i.
- Synchronizer: 2-flop ASYNC_REG chain, reset to the inactive level.
  - Logical sample s = (sync stage 2 == ACTIVE_MASK[i]).
  - Edge 0 is the first CLK edge that captures PIN active; s is first seen by the logic at edge 2.
- Debounce counter: width $clog2(DEBOUNCE_PERIOD+1). Evaluated each edge:
  - s == STATE: counter <= 0.
  - s != STATE and counter+1 < DEBOUNCE_PERIOD: counter <= counter+1.
  - s != STATE and counter+1 == DEBOUNCE_PERIOD: STATE toggles, counter <= 0, PRESS or RELEASE pulses.
  - Any glitch back to STATE before expiry restarts the count from 0. There is no partial credit.
- Latency: pin held active continuously from edge 0 gives STATE = 1 and PRESS = 1 registered at edge DEBOUNCE_PERIOD+1. Release is symmetric.
- Long-press FSM, states IDLE, PRESSED, HELD:
  - IDLE -> PRESSED on the press event; long counter <= 0.
  - PRESSED: long counter increments each cycle. When it reaches LONG_PERIOD-1, LONG pulses and the FSM goes to HELD. LONG is therefore high exactly LONG_PERIOD cycles after the PRESS cycle.
  - HELD: wait; no further LONG pulses for this press.
  - PRESSED or HELD -> IDLE on the release event; long counter cleared.
  - Release on the same edge LONG would fire: the release wins and LONG is not asserted.
  - Long counter width is $clog2(LONG_PERIOD).
- PRESS, RELEASE and LONG are registered; each is high for exactly 1 cycle.
- PRESS and RELEASE are never high together on one channel. LONG is never coincident with PRESS.
- Reset (any time, including mid-debounce or mid-hold):
  - Sync flops go to inactive; STATE, PRESS, RELEASE, LONG = 0; counters = 0; FSM = IDLE.
  - No RELEASE pulse is generated by reset.
  - A pin held active through reset yields a fresh PRESS after DEBOUNCE_PERIOD+1 edges following deassertion.
- Counters saturate naturally (they are cleared on state change), so no wrap-around is possible.

Test Plan:
All scenarios use CHANNELS=4, ACTIVE_MASK=4'b0111, CLOCKS_PER_USEC=1, DEBOUNCE_USEC=4, LONG_PRESS_USEC=20.
1. Clean press: PIN[0] 0->1 before edge 0, held 10 cycles, then 0 -> PRESS[0] high only in the cycle after edge 5; STATE[0] = 1 from edge 5; RELEASE[0] one pulse 5 edges after release is first captured; no LONG[0].
2. Bounce: PIN[1] high 3 cycles, low 1, high 3, low 1, then steady high -> no PRESS[1] during bounce; exactly one PRESS[1] 5 edges after the final rising capture.
3. Long press: PIN[2] held high 40 cycles -> PRESS[2] at cycle c, LONG[2] at exactly c+20, no second LONG; RELEASE[2] after release. Repeat with a release at c+15 -> no LONG[2].
4. Active-low channel: PIN[3] reset high, driven 1->0 -> PRESS[3] and STATE[3] = 1 after 5 edges; a 0->1 transition on PIN[3] produces RELEASE[3], not PRESS[3].
5. Simultaneous channels: PIN[0] and PIN[1] rise on the same edge -> PRESS[0] and PRESS[1] in the same cycle; channels 2 and 3 remain quiet.
6. Reset mid-operation: assert RESET for 2 cycles at count 3 of debounce and again in HELD -> all outputs 0 during reset, no RELEASE generated; with PIN still active, PRESS fires 5 edges after RESET deasserts.

Source files
------------

// File: rtl/button_bank.sv
// Multi-channel debounced button front end: 2-flop sync, symmetric debounce,
// one-cycle press/release pulses, debounced level and one-shot long-press pulse.
//   IDLE    | button not pressed
//   PRESSED | pressed, long-press timer running
//   HELD    | long press already reported, waiting for release
module button_bank #(
  parameter int                    CHANNELS        = 4,
  parameter logic [CHANNELS-1:0]   ACTIVE_MASK     = {CHANNELS{1'b1}},
  parameter int                    CLOCKS_PER_USEC = 125,
  parameter int                    DEBOUNCE_USEC   = 10000,
  parameter int                    LONG_PRESS_USEC = 1000000
) (
  input  logic                CLK,
  input  logic                RESET,
  input  logic [CHANNELS-1:0] PIN,
  output logic [CHANNELS-1:0] STATE,
  output logic [CHANNELS-1:0] PRESS,
  output logic [CHANNELS-1:0] RELEASE,
  output logic [CHANNELS-1:0] LONG
);

  localparam int DEBOUNCE_PERIOD = CLOCKS_PER_USEC * DEBOUNCE_USEC;
  localparam int LONG_PERIOD     = CLOCKS_PER_USEC * LONG_PRESS_USEC;
  localparam int DW              = $clog2(DEBOUNCE_PERIOD + 1);
  localparam int LW              = $clog2(LONG_PERIOD);

  localparam logic [DW-1:0] DB_LAST   = DW'(DEBOUNCE_PERIOD - 1);
  localparam logic [LW-1:0] LONG_LAST = LW'(LONG_PERIOD - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PRESSED = 2'd1,
    HELD    = 2'd2
  } long_state_t;

  for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
    (* ASYNC_REG = "TRUE" *) logic r_sync1;
    (* ASYNC_REG = "TRUE" *) logic r_sync2;
    logic [DW-1:0] r_deb_cnt;
    logic [LW-1:0] r_long_cnt;
    long_state_t   r_fsm;
    logic          r_state;
    logic          r_press;
    logic          r_release;
    logic          r_long;
    logic          w_sample;
    logic          w_expire;
    logic          w_rise;
    logic          w_fall;

    // Sample is in logical (polarity-free) terms: 1 means the button is active.
    assign w_sample = (r_sync2 == ACTIVE_MASK[g]);
    assign w_expire = (w_sample != r_state) && (r_deb_cnt == DB_LAST);
    assign w_rise   = w_expire && !r_state;
    assign w_fall   = w_expire &&  r_state;

    always_ff @(posedge CLK) begin
      if (RESET) begin
        r_sync1    <= ~ACTIVE_MASK[g];
        r_sync2    <= ~ACTIVE_MASK[g];
        r_deb_cnt  <= '0;
        r_long_cnt <= '0;
        r_fsm      <= IDLE;
        r_state    <= 1'b0;
        r_press    <= 1'b0;
        r_release  <= 1'b0;
        r_long     <= 1'b0;
      end else begin
        r_sync1   <= PIN[g];
        r_sync2   <= r_sync1;
        r_press   <= w_rise;
        r_release <= w_fall;
        r_long    <= 1'b0;

        if (w_sample == r_state) begin
          r_deb_cnt <= '0;
        end else if (w_expire) begin
          r_state   <= ~r_state;
          r_deb_cnt <= '0;
        end else begin
          r_deb_cnt <= r_deb_cnt + 1'b1;
        end

        // A release arriving on the terminal count edge suppresses LONG.
        case (r_fsm)
          IDLE: begin
            if (w_rise) begin
              r_fsm      <= PRESSED;
              r_long_cnt <= '0;
            end
          end
          PRESSED: begin
            if (w_fall) begin
              r_fsm      <= IDLE;
              r_long_cnt <= '0;
            end else if (r_long_cnt == LONG_LAST) begin
              r_long <= 1'b1;
              r_fsm  <= HELD;
            end else begin
              r_long_cnt <= r_long_cnt + 1'b1;
            end
          end
          HELD: begin
            if (w_fall) begin
              r_fsm      <= IDLE;
              r_long_cnt <= '0;
            end
          end
          default: begin
            r_fsm      <= IDLE;
            r_long_cnt <= '0;
          end
        endcase
      end
    end

    assign STATE[g]   = r_state;
    assign PRESS[g]   = r_press;
    assign RELEASE[g] = r_release;
    assign LONG[g]    = r_long;
  end

endmodule
